// File: rtl/whack_pkg.sv
// Shared types for the whack detector: FSM state encoding and its width.
package whack_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HIT   = 2'd2
  } state_e;

endpackage

// File: rtl/button_debouncer.sv
// One button: 2-flop synchroniser, hold-time debounce counter, stable level
// and a single-cycle rise pulse when the debounced level goes high.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_raw_i,
  output logic btn_stable_o,
  output logic rise_o
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             stable_d;
  logic             prev_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; otherwise a latch is inferred.
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= btn_raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      prev_q   <= stable_q;
      cnt_q    <= cnt_d;
    end
  end

  assign btn_stable_o = stable_q;
  assign rise_o       = stable_q & ~prev_q;

endmodule

// File: rtl/whack_detector.sv
// Turns debounced button presses plus the mole generator's hole indication
// into single-cycle whacked/miss pulses, allowing one hit per mole appearance.
module whack_detector
  import whack_pkg::*;
#(
  parameter int NUM_HOLES       = 4,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_HOLES-1:0] btn_raw,
  input  logic                 mole_up,
  input  logic [NUM_HOLES-1:0] mole_sel,
  output logic                 whacked,
  output logic                 miss,
  output logic [NUM_HOLES-1:0] btn_stable,
  output logic [STATE_W-1:0]   state
);

  logic [NUM_HOLES-1:0] press;
  logic [NUM_HOLES-1:0] hole_q;
  state_e               state_q;
  logic                 whacked_q;
  logic                 miss_q;
  logic                 hit;
  logic                 any_press;

  for (genvar i = 0; i < NUM_HOLES; i++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
      .clock       (clock),
      .reset       (reset),
      .btn_raw_i   (btn_raw[i]),
      .btn_stable_o(btn_stable[i]),
      .rise_o      (press[i])
    );
  end

  // The latched hole, not the live mole_sel, decides a hit for this appearance.
  assign hit       = |(press & hole_q);
  assign any_press = |press;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      hole_q    <= '0;
      whacked_q <= 1'b0;
      miss_q    <= 1'b0;
    end else begin
      whacked_q <= 1'b0;
      miss_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          miss_q <= any_press;
          if (mole_up) begin
            state_q <= ARMED;
            hole_q  <= mole_sel;
          end
        end
        ARMED: begin
          if (hit) begin
            whacked_q <= 1'b1;
            state_q   <= mole_up ? HIT : IDLE;
          end else begin
            miss_q <= any_press;
            if (!mole_up) state_q <= IDLE;
          end
        end
        HIT: begin
          if (!mole_up) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign whacked = whacked_q;
  assign miss    = miss_q;
  assign state   = state_q;

endmodule

// File: tb/tb_whack_detector.sv
// Directed bench for whack_detector with DEBOUNCE_CYCLES=4: vector table plus
// hand sequences for latency, bounce, same-cycle mole drop and async reset.
module tb_whack_detector;
  import whack_pkg::*;

  localparam int NH = 4;
  localparam int DC = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [NH-1:0] btn_raw;
  logic          mole_up;
  logic [NH-1:0] mole_sel;
  logic          whacked;
  logic          miss;
  logic [NH-1:0] btn_stable;
  logic [1:0]    state;

  int n_tests = 0;
  int n_fail  = 0;
  int w_tot   = 0;
  int m_tot   = 0;
  int score   = 0;
  int w_base;
  int m_base;
  int s_base;

  typedef struct {
    logic [NH-1:0] btn;
    logic          up;
    logic [NH-1:0] sel;
    int            cycles;
    int            exp_w;
    int            exp_m;
    state_e        exp_state;
    logic [NH-1:0] exp_stable;
  } vec_t;

  vec_t vecs[18];

  whack_detector #(
    .NUM_HOLES      (NH),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .btn_raw   (btn_raw),
    .mole_up   (mole_up),
    .mole_sel  (mole_sel),
    .whacked   (whacked),
    .miss      (miss),
    .btn_stable(btn_stable),
    .state     (state)
  );

  always #5 clock = ~clock;

  // Pulse totals and a stand-in score counter, sampled mid-cycle.
  always @(negedge clock) begin
    if (whacked) begin
      w_tot <= w_tot + 1;
      score <= score + 1;
    end
    if (miss) m_tot <= m_tot + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic mark();
    w_base = w_tot;
    m_base = m_tot;
    s_base = score;
  endtask

  initial begin
    vecs[0]  = '{4'b0000, 1'b1, 4'b0010,  2, 0, 0, ARMED, 4'b0000};
    vecs[1]  = '{4'b0001, 1'b1, 4'b0010, 10, 0, 1, ARMED, 4'b0001};
    vecs[2]  = '{4'b0000, 1'b1, 4'b0010, 10, 0, 0, ARMED, 4'b0000};
    vecs[3]  = '{4'b0010, 1'b1, 4'b0010, 10, 1, 0, HIT,   4'b0010};
    vecs[4]  = '{4'b0000, 1'b0, 4'b0000, 10, 0, 0, IDLE,  4'b0000};
    vecs[5]  = '{4'b0000, 1'b1, 4'b0001,  2, 0, 0, ARMED, 4'b0000};
    vecs[6]  = '{4'b0101, 1'b1, 4'b0001, 10, 1, 0, HIT,   4'b0101};
    vecs[7]  = '{4'b0000, 1'b0, 4'b0000, 10, 0, 0, IDLE,  4'b0000};
    vecs[8]  = '{4'b0000, 1'b1, 4'b1000,  2, 0, 0, ARMED, 4'b0000};
    vecs[9]  = '{4'b0000, 1'b1, 4'b0100,  2, 0, 0, ARMED, 4'b0000};
    vecs[10] = '{4'b0100, 1'b1, 4'b0100, 10, 0, 1, ARMED, 4'b0100};
    vecs[11] = '{4'b0000, 1'b0, 4'b0000, 10, 0, 0, IDLE,  4'b0000};
    vecs[12] = '{4'b0010, 1'b0, 4'b0000, 10, 0, 1, IDLE,  4'b0010};
    vecs[13] = '{4'b0000, 1'b0, 4'b0000, 10, 0, 0, IDLE,  4'b0000};
    vecs[14] = '{4'b1000, 1'b1, 4'b1000, 10, 1, 0, HIT,   4'b1000};
    vecs[15] = '{4'b0000, 1'b1, 4'b1000, 10, 0, 0, HIT,   4'b0000};
    vecs[16] = '{4'b1000, 1'b1, 4'b1000, 10, 0, 0, HIT,   4'b1000};
    vecs[17] = '{4'b0000, 1'b0, 4'b0000, 10, 0, 0, IDLE,  4'b0000};

    reset    = 1'b0;
    btn_raw  = '0;
    mole_up  = 1'b0;
    mole_sel = '0;
    tick(3);
    check("rst_whacked", whacked, 0);
    check("rst_miss", miss, 0);
    check("rst_stable", btn_stable, 0);
    check("rst_state", state, IDLE);
    reset = 1'b1;
    tick(1);
    check("post_rst_state", state, IDLE);

    // Latency: press lands before edge k, whacked is high after edge k+DC+2.
    mole_up  = 1'b1;
    mole_sel = 4'b0100;
    tick(1);
    check("lat_armed", state, ARMED);
    btn_raw = 4'b0100;
    mark();
    for (int t = 1; t <= 8; t++) begin
      tick(1);
      check($sformatf("lat_whacked_t%0d", t), whacked, (t == 7));
      if (t == 5) check("lat_stable_t5", btn_stable, 4'b0000);
      if (t == 6) check("lat_stable_t6", btn_stable, 4'b0100);
      if (t == 7) check("lat_state_hit", state, HIT);
    end
    tick(20);
    check("hold_one_whack", w_tot - w_base, 1);
    check("hold_no_miss", m_tot - m_base, 0);
    check("hold_state", state, HIT);
    btn_raw = '0;
    mole_up = 1'b0;
    tick(10);
    check("lat_back_idle", state, IDLE);

    for (int v = 0; v < 18; v++) begin
      btn_raw  = vecs[v].btn;
      mole_up  = vecs[v].up;
      mole_sel = vecs[v].sel;
      mark();
      tick(vecs[v].cycles);
      check($sformatf("vec%0d_whacked", v), w_tot - w_base, vecs[v].exp_w);
      check($sformatf("vec%0d_miss", v), m_tot - m_base, vecs[v].exp_m);
      check($sformatf("vec%0d_state", v), state, vecs[v].exp_state);
      check($sformatf("vec%0d_stable", v), btn_stable, vecs[v].exp_stable);
      if (v == 6) check("simul_score_step", score - s_base, 1);
    end

    // Bounce: two-cycle toggles never hold long enough to be accepted.
    mole_up  = 1'b1;
    mole_sel = 4'b1000;
    tick(2);
    mark();
    for (int i = 0; i < 10; i++) begin
      btn_raw = (i % 2 == 0) ? 4'b1000 : 4'b0000;
      tick(2);
      check($sformatf("bounce_stable_%0d", i), btn_stable[3], 0);
    end
    check("bounce_no_whack", w_tot - w_base, 0);
    check("bounce_no_miss", m_tot - m_base, 0);
    btn_raw = 4'b1000;
    mark();
    tick(10);
    check("bounce_then_whack", w_tot - w_base, 1);
    check("bounce_then_miss", m_tot - m_base, 0);
    btn_raw = '0;
    mole_up = 1'b0;
    tick(10);

    // Mole drops in the very cycle the matching press is detected.
    mole_up  = 1'b1;
    mole_sel = 4'b0010;
    tick(2);
    btn_raw = 4'b0010;
    tick(6);
    mole_up = 1'b0;
    tick(1);
    check("drop_whacked", whacked, 1);
    check("drop_miss", miss, 0);
    check("drop_state", state, IDLE);
    btn_raw = '0;
    tick(10);
    btn_raw = 4'b0100;
    mark();
    tick(10);
    check("idle_press_miss", m_tot - m_base, 1);
    check("idle_press_whack", w_tot - w_base, 0);
    btn_raw = '0;
    tick(10);

    // Asynchronous reset mid-ARMED with a debounce in flight.
    mole_up  = 1'b1;
    mole_sel = 4'b0001;
    tick(2);
    check("pre_reset_armed", state, ARMED);
    btn_raw = 4'b0001;
    tick(3);
    #2 reset = 1'b0;
    #1;
    check("async_rst_state", state, IDLE);
    check("async_rst_whacked", whacked, 0);
    check("async_rst_miss", miss, 0);
    check("async_rst_stable", btn_stable, 0);
    tick(2);
    reset = 1'b1;
    mark();
    tick(12);
    check("held_after_rst_whack", w_tot - w_base, 1);
    check("held_after_rst_state", state, HIT);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
